// File: rtl/openhw_postproc_arb_pkg.sv
// rtl/openhw_postproc_arb_pkg.sv - shared FPU post-processor control types and widths
package openhw_postproc_arb_pkg;

  localparam int FRM_W = 3;
  localparam int PP_FMTW = 2;
  localparam int PP_TAGW = 5;

  typedef struct packed {
    logic               Xs;
    logic               Ys;
    logic               Sqrt;
    logic               CvtCs;
    logic               FmaSs;
    logic               FmaOp;
    logic               DivOp;
    logic               CvtOp;
    logic [FRM_W-1:0]   Frm;
    logic [PP_FMTW-1:0] Fmt;
    logic [PP_TAGW-1:0] Tag;
  } postproc_ctrl_t;

endpackage

// File: rtl/openhw_rr_arb2.sv
// rtl/openhw_rr_arb2.sv - two-requester round-robin arbiter (pipe vs divsqrt)
module openhw_rr_arb2 (
  input  logic clk,
  input  logic reset_n,
  input  logic load_en,
  input  logic flush,
  input  logic pipe_valid,
  input  logic div_valid,
  output logic pipe_ready,
  output logic div_ready,
  output logic grant_pipe,
  output logic grant_div
);

  logic last_div;

  // Readies look only at the other source's valid, so no valid ever waits on a ready.
  assign pipe_ready = load_en & ~flush & (~div_valid | last_div);
  assign div_ready  = load_en & ~flush & (~pipe_valid | ~last_div);
  assign grant_pipe = pipe_valid & pipe_ready;
  assign grant_div  = div_valid & div_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        last_div <= 1'b0;
    else if (grant_div)  last_div <= 1'b1;
    else if (grant_pipe) last_div <= 1'b0;
  end

  grant_onehot: assert property (@(posedge clk) disable iff (!reset_n) !(grant_pipe && grant_div));

endmodule

// File: rtl/openhw_postproc_arb.sv
// rtl/openhw_postproc_arb.sv - merges FMA/cvt and divsqrt results into one staged post-processor stream
module openhw_postproc_arb
  import openhw_postproc_arb_pkg::*;
#(
  parameter int TAGW = 5,
  parameter int FMTW = 2,
  parameter int CNTW = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             Flush,
  input  logic             PipeValid,
  output logic             PipeReady,
  input  logic             PipeFmaOp,
  input  logic             PipeFmaSs,
  input  logic             PipeCvtCs,
  input  logic [FRM_W-1:0] PipeFrm,
  input  logic [FMTW-1:0]  PipeFmt,
  input  logic [TAGW-1:0]  PipeTag,
  input  logic             DivValid,
  output logic             DivReady,
  input  logic             DivXs,
  input  logic             DivYs,
  input  logic             DivSqrt,
  input  logic [FRM_W-1:0] DivFrm,
  input  logic [FMTW-1:0]  DivFmt,
  input  logic [TAGW-1:0]  DivTag,
  output logic             PostValid,
  input  logic             PostReady,
  output logic             Xs,
  output logic             Ys,
  output logic             Sqrt,
  output logic             CvtCs,
  output logic             FmaSs,
  output logic             FmaOp,
  output logic             CvtOp,
  output logic             DivOp,
  output logic [FRM_W-1:0] Frm,
  output logic [FMTW-1:0]  Fmt,
  output logic [TAGW-1:0]  Tag,
  output logic [CNTW-1:0]  StallCnt
);

  postproc_ctrl_t ctrl_d, ctrl_q;
  logic           load_en, grant_pipe, grant_div, post_valid;
  logic [CNTW-1:0] stall_cnt;

  // Gating with reset_n keeps both sources un-acked while reset is held.
  assign load_en = reset_n & (~post_valid | PostReady);

  openhw_rr_arb2 u_arb (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_en    (load_en),
    .flush      (Flush),
    .pipe_valid (PipeValid),
    .div_valid  (DivValid),
    .pipe_ready (PipeReady),
    .div_ready  (DivReady),
    .grant_pipe (grant_pipe),
    .grant_div  (grant_div)
  );

  always_comb begin
    ctrl_d = '0;
    if (grant_div) begin
      ctrl_d.DivOp = 1'b1;
      ctrl_d.Xs    = DivXs;
      ctrl_d.Ys    = DivYs;
      ctrl_d.Sqrt  = DivSqrt;
      ctrl_d.Frm   = DivFrm;
      ctrl_d.Fmt   = PP_FMTW'(DivFmt);
      ctrl_d.Tag   = PP_TAGW'(DivTag);
    end else begin
      ctrl_d.FmaOp = PipeFmaOp;
      ctrl_d.CvtOp = ~PipeFmaOp;
      ctrl_d.FmaSs = PipeFmaSs & PipeFmaOp;
      ctrl_d.CvtCs = PipeCvtCs & ~PipeFmaOp;
      ctrl_d.Frm   = PipeFrm;
      ctrl_d.Fmt   = PP_FMTW'(PipeFmt);
      ctrl_d.Tag   = PP_TAGW'(PipeTag);
    end
  end

  // Data fields only move on a grant; a flush merely invalidates them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q     <= '0;
      post_valid <= 1'b0;
    end else begin
      if (grant_pipe | grant_div) ctrl_q <= ctrl_d;
      if (Flush)        post_valid <= 1'b0;
      else if (load_en) post_valid <= grant_pipe | grant_div;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stall_cnt <= '0;
    else if (post_valid & ~PostReady & ~Flush & ~(&stall_cnt))
      stall_cnt <= stall_cnt + 1'b1;
  end

  assign PostValid = post_valid;
  assign Xs        = ctrl_q.Xs;
  assign Ys        = ctrl_q.Ys;
  assign Sqrt      = ctrl_q.Sqrt;
  assign CvtCs     = ctrl_q.CvtCs;
  assign FmaSs     = ctrl_q.FmaSs;
  assign FmaOp     = ctrl_q.FmaOp;
  assign CvtOp     = ctrl_q.CvtOp;
  assign DivOp     = ctrl_q.DivOp;
  assign Frm       = ctrl_q.Frm;
  assign Fmt       = FMTW'(ctrl_q.Fmt);
  assign Tag       = TAGW'(ctrl_q.Tag);
  assign StallCnt  = stall_cnt;

endmodule

// File: tb/tb_openhw_postproc_arb.sv
// tb/tb_openhw_postproc_arb.sv - directed self-checking bench for openhw_postproc_arb
module tb_openhw_postproc_arb;

  logic        clk = 1'b0;
  logic        reset_n, Flush;
  logic        PipeValid, PipeReady, PipeFmaOp, PipeFmaSs, PipeCvtCs;
  logic [2:0]  PipeFrm, DivFrm, Frm;
  logic [1:0]  PipeFmt, DivFmt, Fmt;
  logic [4:0]  PipeTag, DivTag, Tag;
  logic        DivValid, DivReady, DivXs, DivYs, DivSqrt;
  logic        PostValid, PostReady;
  logic        Xs, Ys, Sqrt, CvtCs, FmaSs, FmaOp, CvtOp, DivOp;
  logic [15:0] StallCnt;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  openhw_postproc_arb #(.TAGW(5), .FMTW(2), .CNTW(16)) dut (
    .clk(clk), .reset_n(reset_n), .Flush(Flush),
    .PipeValid(PipeValid), .PipeReady(PipeReady), .PipeFmaOp(PipeFmaOp),
    .PipeFmaSs(PipeFmaSs), .PipeCvtCs(PipeCvtCs), .PipeFrm(PipeFrm),
    .PipeFmt(PipeFmt), .PipeTag(PipeTag),
    .DivValid(DivValid), .DivReady(DivReady), .DivXs(DivXs), .DivYs(DivYs),
    .DivSqrt(DivSqrt), .DivFrm(DivFrm), .DivFmt(DivFmt), .DivTag(DivTag),
    .PostValid(PostValid), .PostReady(PostReady),
    .Xs(Xs), .Ys(Ys), .Sqrt(Sqrt), .CvtCs(CvtCs), .FmaSs(FmaSs),
    .FmaOp(FmaOp), .CvtOp(CvtOp), .DivOp(DivOp),
    .Frm(Frm), .Fmt(Fmt), .Tag(Tag), .StallCnt(StallCnt)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    Flush = 0; PipeValid = 0; PipeFmaOp = 0; PipeFmaSs = 0; PipeCvtCs = 0;
    PipeFrm = 0; PipeFmt = 0; PipeTag = 0;
    DivValid = 0; DivXs = 0; DivYs = 0; DivSqrt = 0; DivFrm = 0; DivFmt = 0; DivTag = 0;
    PostReady = 1;
  endtask

  task automatic do_reset();
    reset_n = 0;
    tick();
    reset_n = 1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    PipeValid = 1; DivValid = 1;
    #3;
    n_checks++; if (PostValid !== 1'b0) begin n_fail++; $display("FAIL reset_postvalid: got %b want 0", PostValid); end
    n_checks++; if (StallCnt !== 16'd0) begin n_fail++; $display("FAIL reset_stallcnt: got %0d want 0", StallCnt); end
    n_checks++; if ({FmaOp, CvtOp, DivOp, Tag} !== 8'd0) begin n_fail++; $display("FAIL reset_fields: got %h want 0", {FmaOp, CvtOp, DivOp, Tag}); end
    n_checks++; if ({PipeReady, DivReady} !== 2'b00) begin n_fail++; $display("FAIL reset_readies: got %b want 00", {PipeReady, DivReady}); end
    tick();
    idle_inputs();
    reset_n = 1;
    tick();
  endtask

  task automatic test_pipe_only();
    PipeValid = 1; PipeFmaOp = 1; PipeFmaSs = 1; PipeCvtCs = 1; PipeTag = 3; PipeFrm = 3'd2; PipeFmt = 2'd1;
    #1;
    n_checks++; if (PipeReady !== 1'b1) begin n_fail++; $display("FAIL pipe_ready: got %b want 1", PipeReady); end
    tick();
    PipeValid = 0;
    n_checks++; if (PostValid !== 1'b1) begin n_fail++; $display("FAIL pipe_postvalid: got %b want 1", PostValid); end
    n_checks++; if ({FmaOp, CvtOp, DivOp, FmaSs, CvtCs, Xs} !== 6'b100100) begin n_fail++; $display("FAIL pipe_fma_fields: got %b want 100100", {FmaOp, CvtOp, DivOp, FmaSs, CvtCs, Xs}); end
    n_checks++; if ({Tag, Frm, Fmt} !== {5'd3, 3'd2, 2'd1}) begin n_fail++; $display("FAIL pipe_tag_frm_fmt: got %h want %h", {Tag, Frm, Fmt}, {5'd3, 3'd2, 2'd1}); end
    // Convert result: FmaSs must be masked off, CvtCs passed through.
    PipeValid = 1; PipeFmaOp = 0; PipeFmaSs = 1; PipeCvtCs = 1; PipeTag = 4;
    tick();
    PipeValid = 0;
    n_checks++; if ({FmaOp, CvtOp, DivOp, FmaSs, CvtCs, Tag} !== {5'b01001, 5'd4}) begin n_fail++; $display("FAIL pipe_cvt_fields: got %b want %b", {FmaOp, CvtOp, DivOp, FmaSs, CvtCs, Tag}, {5'b01001, 5'd4}); end
    tick();
    n_checks++; if (PostValid !== 1'b0) begin n_fail++; $display("FAIL pipe_drain: got %b want 0", PostValid); end
  endtask

  task automatic test_div_only();
    int hs = 0;
    DivValid = 1; DivXs = 1; DivYs = 1; DivSqrt = 1; DivTag = 7; DivFrm = 3'd4; DivFmt = 2'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (DivValid && DivReady) hs++;
      tick();
      DivValid = 0;
      if (i == 0) begin
        n_checks++; if ({DivOp, FmaOp, CvtOp, Xs, Ys, Sqrt, FmaSs, CvtCs} !== 8'b10011100) begin n_fail++; $display("FAIL div_fields: got %b want 10011100", {DivOp, FmaOp, CvtOp, Xs, Ys, Sqrt, FmaSs, CvtCs}); end
        n_checks++; if ({Tag, Frm, Fmt} !== {5'd7, 3'd4, 2'd3}) begin n_fail++; $display("FAIL div_tag_frm_fmt: got %h want %h", {Tag, Frm, Fmt}, {5'd7, 3'd4, 2'd3}); end
      end
    end
    n_checks++; if (hs !== 1) begin n_fail++; $display("FAIL div_handshakes: got %0d want 1", hs); end
  endtask

  task automatic test_both_valid();
    logic exp_div;
    do_reset();
    PipeValid = 1; PipeFmaOp = 1; PipeTag = 10;
    DivValid = 1; DivTag = 20;
    for (int i = 0; i < 4; i++) begin
      exp_div = (i % 2 == 0);
      #1;
      n_checks++; if ({DivReady, PipeReady} !== {exp_div, ~exp_div}) begin n_fail++; $display("FAIL both_readies_%0d: got %b want %b", i, {DivReady, PipeReady}, {exp_div, ~exp_div}); end
      tick();
      n_checks++; if ({PostValid, DivOp, FmaOp, Tag} !== {1'b1, exp_div, ~exp_div, exp_div ? 5'd20 : 5'd10}) begin n_fail++; $display("FAIL both_grant_%0d: got %b want %b", i, {PostValid, DivOp, FmaOp, Tag}, {1'b1, exp_div, ~exp_div, exp_div ? 5'd20 : 5'd10}); end
    end
    PipeValid = 0; DivValid = 0;
    tick();
  endtask

  task automatic test_backpressure();
    DivValid = 1; DivTag = 5; PostReady = 1;
    tick();
    DivValid = 0;
    PostReady = 0;
    PipeValid = 1; PipeFmaOp = 1; PipeTag = 9;
    n_checks++; if (StallCnt !== 16'd0) begin n_fail++; $display("FAIL bp_stall_start: got %0d want 0", StallCnt); end
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if ({PipeReady, DivReady} !== 2'b00) begin n_fail++; $display("FAIL bp_readies_%0d: got %b want 00", i, {PipeReady, DivReady}); end
      tick();
      n_checks++; if ({PostValid, DivOp, Tag} !== {2'b11, 5'd5}) begin n_fail++; $display("FAIL bp_frozen_%0d: got %b want %b", i, {PostValid, DivOp, Tag}, {2'b11, 5'd5}); end
      n_checks++; if (StallCnt !== 16'(i + 1)) begin n_fail++; $display("FAIL bp_stallcnt_%0d: got %0d want %0d", i, StallCnt, i + 1); end
    end
    PostReady = 1;
    #1;
    n_checks++; if (PipeReady !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", PipeReady); end
    tick();
    n_checks++; if ({PostValid, FmaOp, DivOp, Tag, StallCnt} !== {3'b110, 5'd9, 16'd5}) begin n_fail++; $display("FAIL bp_release_load: got %h want %h", {PostValid, FmaOp, DivOp, Tag, StallCnt}, {3'b110, 5'd9, 16'd5}); end
  endtask

  task automatic test_flush();
    PipeValid = 1; PipeFmaOp = 0; PipeTag = 11; Flush = 1; PostReady = 1;
    #1;
    n_checks++; if ({PipeReady, DivReady} !== 2'b00) begin n_fail++; $display("FAIL flush_readies: got %b want 00", {PipeReady, DivReady}); end
    tick();
    Flush = 0;
    n_checks++; if (PostValid !== 1'b0) begin n_fail++; $display("FAIL flush_postvalid: got %b want 0", PostValid); end
    #1;
    n_checks++; if (PipeReady !== 1'b1) begin n_fail++; $display("FAIL flush_after_ready: got %b want 1", PipeReady); end
    tick();
    PipeValid = 0;
    n_checks++; if ({PostValid, CvtOp, FmaOp, Tag} !== {3'b110, 5'd11}) begin n_fail++; $display("FAIL flush_reload: got %b want %b", {PostValid, CvtOp, FmaOp, Tag}, {3'b110, 5'd11}); end
  endtask

  task automatic test_async_reset();
    PostReady = 0;
    tick();
    n_checks++; if ({PostValid, StallCnt} !== {1'b1, 16'd6}) begin n_fail++; $display("FAIL ar_pre_state: got %h want %h", {PostValid, StallCnt}, {1'b1, 16'd6}); end
    PipeValid = 1; PipeFmaOp = 1; PipeTag = 12;
    DivValid = 1; DivTag = 13;
    #2 reset_n = 0;
    #1;
    n_checks++; if ({PostValid, CvtOp, FmaOp, DivOp, Tag, StallCnt} !== 25'd0) begin n_fail++; $display("FAIL ar_cleared: got %h want 0", {PostValid, CvtOp, FmaOp, DivOp, Tag, StallCnt}); end
    #1 reset_n = 1;
    PostReady = 1;
    #1;
    n_checks++; if ({DivReady, PipeReady} !== 2'b10) begin n_fail++; $display("FAIL ar_first_ready: got %b want 10", {DivReady, PipeReady}); end
    tick();
    n_checks++; if ({PostValid, DivOp, Tag} !== {2'b11, 5'd13}) begin n_fail++; $display("FAIL ar_first_grant: got %b want %b", {PostValid, DivOp, Tag}, {2'b11, 5'd13}); end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_pipe_only();
    test_div_only();
    test_both_valid();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
